// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, memory-stall and overflow-trap control for a 5-stage pipe.
// Optional trap logic is compiled in when PIPE_CTRL_EXC_EN is defined.
module pipe_ctrl #(
   parameter int unsigned EXC_HOLD = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             init,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             idex_memreg,
   input  logic [4:0]       idex_rd,
   input  logic             exmem_branch,
   input  logic             exmem_zero,
   input  logic             exmem_overflow,
   input  logic [31:0]      exmem_pcplus4,
   input  logic             mem_ready,
   input  logic             stall_clr,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             pipe_we,
   output logic [1:0]       pc_sel,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic [31:0]      epc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [2:0]       state
);

   localparam logic [2:0] S_RUN      = 3'd0;
   localparam logic [2:0] S_MEM_WAIT = 3'd1;
   localparam logic [2:0] S_EXC      = 3'd2;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             ovf;
   logic             taken;
   logic             lu_hz;
   logic             trap;

`ifdef PIPE_CTRL_EXC_EN
   logic [3:0]  hold_q, hold_d;
   logic [31:0] epc_q, epc_d;

   assign ovf = exmem_overflow;
   assign epc = epc_q;
`else
   logic unused_exc;

   assign unused_exc = exmem_overflow ^ (^exmem_pcplus4);
   assign ovf        = 1'b0;
   assign epc        = 32'd0;
`endif

   assign taken = exmem_branch & exmem_zero;
   assign lu_hz = idex_memreg && (idex_rd != 5'd0) &&
                  ((idex_rd == id_rs) || (idex_rd == id_rt));

   // Next state and per-cycle pipeline controls, by priority.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      pipe_we     = 1'b1;
      pc_sel      = 2'b00;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      trap        = 1'b0;
      state_d     = state_q;
      case (state_q)
         S_RUN, S_MEM_WAIT: begin
            state_d = S_RUN;
            if (ovf) begin
               trap        = 1'b1;
               pc_sel      = 2'b10;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               memwb_flush = 1'b1;
               state_d     = S_EXC;
            end else if (!mem_ready) begin
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               pipe_we = 1'b0;
               state_d = S_MEM_WAIT;
            end else if (taken) begin
               pc_sel      = 2'b01;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end else if (lu_hz) begin
               pc_we      = 1'b0;
               ifid_we    = 1'b0;
               idex_flush = 1'b1;
            end
         end
`ifdef PIPE_CTRL_EXC_EN
         S_EXC: begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            state_d    = (hold_q <= 4'd1) ? S_RUN : S_EXC;
         end
`endif
         default: state_d = S_RUN;
      endcase
      if (!init) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         pipe_we     = 1'b0;
         pc_sel      = 2'b00;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end
`ifndef PIPE_CTRL_EXC_EN
      memwb_flush = 1'b0;
`endif
   end

   // Stall counter: clear wins, otherwise saturating count of frozen-PC cycles.
   always_comb begin
      stall_d = stall_q;
      if (stall_clr)
         stall_d = '0;
      else if (!pc_we && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + 1'b1;
   end

   // State and stall counter registers.
   always_ff @(posedge clk or negedge init) begin
      if (!init) begin
         state_q <= S_RUN;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

`ifdef PIPE_CTRL_EXC_EN
   // Trap bookkeeping: capture the faulting PC and load the drain counter.
   always_comb begin
      hold_d = hold_q;
      epc_d  = epc_q;
      if (trap) begin
         hold_d = 4'(EXC_HOLD);
         epc_d  = exmem_pcplus4 - 32'd4;
      end else if (state_q == S_EXC && hold_q != 4'd0) begin
         hold_d = hold_q - 4'd1;
      end
   end

   // Trap registers.
   always_ff @(posedge clk or negedge init) begin
      if (!init) begin
         hold_q <= 4'd0;
         epc_q  <= 32'd0;
      end else begin
         hold_q <= hold_d;
         epc_q  <= epc_d;
      end
   end
`endif

   assign stall_cnt = stall_q;
   assign state     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl with a 4-bit stall counter.
// Trap expectations follow PIPE_CTRL_EXC_EN.
module tb_pipe_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          init;
   logic [4:0]    id_rs, id_rt, idex_rd;
   logic          idex_memreg;
   logic          exmem_branch, exmem_zero, exmem_overflow;
   logic [31:0]   exmem_pcplus4;
   logic          mem_ready, stall_clr;
   logic          pc_we, ifid_we, pipe_we;
   logic [1:0]    pc_sel;
   logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic [31:0]   epc;
   logic [CW-1:0] stall_cnt;
   logic [2:0]    state;

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(.EXC_HOLD(2), .CNT_W(CW)) dut (
      .clk(clk), .init(init),
      .id_rs(id_rs), .id_rt(id_rt),
      .idex_memreg(idex_memreg), .idex_rd(idex_rd),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
      .exmem_overflow(exmem_overflow), .exmem_pcplus4(exmem_pcplus4),
      .mem_ready(mem_ready), .stall_clr(stall_clr),
      .pc_we(pc_we), .ifid_we(ifid_we), .pipe_we(pipe_we),
      .pc_sel(pc_sel),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .epc(epc), .stall_cnt(stall_cnt), .state(state)
   );

   always #5 clk = ~clk;

   task automatic idle();
      id_rs          = 5'd1;
      id_rt          = 5'd2;
      idex_memreg    = 1'b0;
      idex_rd        = 5'd3;
      exmem_branch   = 1'b0;
      exmem_zero     = 1'b0;
      exmem_overflow = 1'b0;
      exmem_pcplus4  = 32'h0000_1000;
      mem_ready      = 1'b1;
      stall_clr      = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] en;
      logic [3:0] fl;
      logic [3:0] fl_exp;
      init = 1'b0;
      idle();
      #1;
      en = {pc_we, ifid_we, pipe_we, 1'b0};
      checks++;
      if (en !== 4'b0000) begin
         errors++;
         $display("FAIL reset_en: got %b expected 0000", en);
      end
`ifdef PIPE_CTRL_EXC_EN
      fl_exp = 4'b1111;
`else
      fl_exp = 4'b1110;
`endif
      fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
      checks++;
      if (fl !== fl_exp) begin
         errors++;
         $display("FAIL reset_flush: got %b expected %b", fl, fl_exp);
      end
      checks++;
      if (pc_sel !== 2'b00) begin
         errors++;
         $display("FAIL reset_pc_sel: got %b expected 00", pc_sel);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({state, stall_cnt} !== {3'd0, 4'd0} || epc !== 32'd0) begin
         errors++;
         $display("FAIL reset_regs: got state=%0d cnt=%0d epc=%h expected 0 0 0",
                  state, stall_cnt, epc);
      end
      init = 1'b1;
   endtask

   task automatic test_idle();
      #1;
      checks++;
      if ({pc_we, ifid_we, pipe_we, pc_sel, ifid_flush, idex_flush,
           exmem_flush, memwb_flush} !== 9'b111_00_0000) begin
         errors++;
         $display("FAIL idle: got we=%b%b%b sel=%b fl=%b%b%b%b expected 111 00 0000",
                  pc_we, ifid_we, pipe_we, pc_sel, ifid_flush, idex_flush,
                  exmem_flush, memwb_flush);
      end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      idex_memreg = 1'b1;
      idex_rd     = 5'd8;
      id_rt       = 5'd8;
      #1;
      checks++;
      if ({pc_we, ifid_we, idex_flush, pipe_we} !== 4'b0011) begin
         errors++;
         $display("FAIL lu_rt: got pc_we=%b ifid_we=%b idex_flush=%b pipe_we=%b expected 0 0 1 1",
                  pc_we, ifid_we, idex_flush, pipe_we);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (pc_we !== 1'b1 || stall_cnt !== 4'd1 || state !== 3'd0) begin
         errors++;
         $display("FAIL lu_bubble: got pc_we=%b cnt=%0d state=%0d expected 1 1 0",
                  pc_we, stall_cnt, state);
      end
      @(negedge clk);
      idex_memreg = 1'b1;
      idex_rd     = 5'd0;
      id_rt       = 5'd0;
      id_rs       = 5'd0;
      #1;
      checks++;
      if (pc_we !== 1'b1 || idex_flush !== 1'b0) begin
         errors++;
         $display("FAIL lu_r0: got pc_we=%b idex_flush=%b expected 1 0",
                  pc_we, idex_flush);
      end
      @(negedge clk);
      idex_rd = 5'd5;
      id_rs   = 5'd5;
      id_rt   = 5'd9;
      #1;
      checks++;
      if (stall_cnt !== 4'd1 || pc_we !== 1'b0) begin
         errors++;
         $display("FAIL lu_rs: got cnt=%0d pc_we=%b expected 1 0", stall_cnt, pc_we);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (stall_cnt !== 4'd2) begin
         errors++;
         $display("FAIL lu_rs_cnt: got %0d expected 2", stall_cnt);
      end
   endtask

   task automatic test_mem_wait();
      @(negedge clk);
      stall_clr = 1'b1;
      @(negedge clk);
      stall_clr    = 1'b0;
      mem_ready    = 1'b0;
      exmem_branch = 1'b1;
      exmem_zero   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if ({pc_we, ifid_we, pipe_we, pc_sel, ifid_flush, idex_flush,
              exmem_flush} !== 8'b000_00_000 ||
             state !== ((i == 0) ? 3'd0 : 3'd1) || stall_cnt !== 4'(i)) begin
            errors++;
            $display("FAIL mem_wait[%0d]: got we=%b%b%b sel=%b state=%0d cnt=%0d expected 000 00 %0d %0d",
                     i, pc_we, ifid_we, pipe_we, pc_sel, state, stall_cnt,
                     (i == 0) ? 0 : 1, i);
         end
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      checks++;
      if (pc_sel !== 2'b01 || pc_we !== 1'b1 ||
          {ifid_flush, idex_flush, exmem_flush, memwb_flush} !== 4'b1110 ||
          state !== 3'd1 || stall_cnt !== 4'd3) begin
         errors++;
         $display("FAIL mem_release: got sel=%b pc_we=%b fl=%b%b%b%b state=%0d cnt=%0d expected 01 1 1110 1 3",
                  pc_sel, pc_we, ifid_flush, idex_flush, exmem_flush,
                  memwb_flush, state, stall_cnt);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (state !== 3'd0 || stall_cnt !== 4'd3) begin
         errors++;
         $display("FAIL mem_after: got state=%0d cnt=%0d expected 0 3", state, stall_cnt);
      end
   endtask

   task automatic test_overflow();
      @(negedge clk);
      stall_clr = 1'b1;
      @(negedge clk);
      stall_clr      = 1'b0;
      exmem_overflow = 1'b1;
      exmem_branch   = 1'b1;
      exmem_zero     = 1'b1;
      exmem_pcplus4  = 32'h0040_0024;
      #1;
`ifdef PIPE_CTRL_EXC_EN
      checks++;
      if (pc_sel !== 2'b10 || pc_we !== 1'b1 ||
          {ifid_flush, idex_flush, exmem_flush, memwb_flush} !== 4'b1111) begin
         errors++;
         $display("FAIL ovf_trap: got sel=%b pc_we=%b fl=%b%b%b%b expected 10 1 1111",
                  pc_sel, pc_we, ifid_flush, idex_flush, exmem_flush, memwb_flush);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 3'd2 || epc !== 32'h0040_0020) begin
         errors++;
         $display("FAIL ovf_epc: got state=%0d epc=%h expected 2 00400020", state, epc);
      end
      checks++;
      if ({pc_we, ifid_we, pipe_we, ifid_flush, idex_flush, pc_sel} !== 7'b01110_00) begin
         errors++;
         $display("FAIL exc_ctl: got we=%b%b%b fl=%b%b sel=%b expected 011 10 00",
                  pc_we, ifid_we, pipe_we, ifid_flush, idex_flush, pc_sel);
      end
      @(negedge clk);
      #1;
      checks++;
      if (state !== 3'd2) begin
         errors++;
         $display("FAIL exc_hold: got state=%0d expected 2", state);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (state !== 3'd0 || stall_cnt !== 4'd2 || pc_we !== 1'b1 ||
          epc !== 32'h0040_0020) begin
         errors++;
         $display("FAIL exc_exit: got state=%0d cnt=%0d pc_we=%b epc=%h expected 0 2 1 00400020",
                  state, stall_cnt, pc_we, epc);
      end
`else
      checks++;
      if (pc_sel !== 2'b01 || memwb_flush !== 1'b0 || idex_flush !== 1'b1 ||
          epc !== 32'd0) begin
         errors++;
         $display("FAIL ovf_off: got sel=%b memwb=%b idex=%b epc=%h expected 01 0 1 0",
                  pc_sel, memwb_flush, idex_flush, epc);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (state !== 3'd0 || epc !== 32'd0) begin
         errors++;
         $display("FAIL ovf_off_state: got state=%0d epc=%h expected 0 0", state, epc);
      end
`endif
   endtask

   task automatic test_saturate();
      @(negedge clk);
      stall_clr = 1'b1;
      @(negedge clk);
      stall_clr   = 1'b0;
      idex_memreg = 1'b1;
      idex_rd     = 5'd8;
      id_rt       = 5'd8;
      #1;
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL sat_start: got %0d expected 0", stall_cnt);
      end
      repeat (15) @(negedge clk);
      #1;
      checks++;
      if (stall_cnt !== 4'd15) begin
         errors++;
         $display("FAIL sat_full: got %0d expected 15", stall_cnt);
      end
      @(negedge clk);
      #1;
      checks++;
      if (stall_cnt !== 4'd15) begin
         errors++;
         $display("FAIL sat_hold: got %0d expected 15", stall_cnt);
      end
      @(negedge clk);
      stall_clr = 1'b1;
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL sat_clr: got %0d expected 0", stall_cnt);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
`ifdef PIPE_CTRL_EXC_EN
      exmem_overflow = 1'b1;
      exmem_pcplus4  = 32'h0000_0100;
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (state !== 3'd2 || epc !== 32'h0000_00fc) begin
         errors++;
         $display("FAIL mid_enter: got state=%0d epc=%h expected 2 000000fc", state, epc);
      end
`else
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (state !== 3'd1) begin
         errors++;
         $display("FAIL mid_enter: got state=%0d expected 1", state);
      end
`endif
      #2;
      init = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || epc !== 32'd0 || stall_cnt !== 4'd0 || pc_we !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got state=%0d epc=%h cnt=%0d pc_we=%b expected 0 0 0 0",
                  state, epc, stall_cnt, pc_we);
      end
      @(negedge clk);
      init = 1'b1;
      idle();
      @(negedge clk);
      #1;
      checks++;
      if (state !== 3'd0 || pc_sel !== 2'b00 || pc_we !== 1'b1 || epc !== 32'd0) begin
         errors++;
         $display("FAIL mid_resume: got state=%0d sel=%b pc_we=%b epc=%h expected 0 00 1 0",
                  state, pc_sel, pc_we, epc);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_load_use();
      test_mem_wait();
      test_overflow();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
